// File: rtl/nn_frame_seq_if.sv
// Stream, core-port and result-handshake bundle for nn_frame_seq.
// The master modport is the sequencer side; the slave modport is the stream source, nn_core and the result sink.
interface nn_frame_seq_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    logic       core_pix_we;
    logic [9:0] core_pix_addr;
    logic [7:0] core_pix_data;
    logic       core_start;
    logic       core_done;
    logic [3:0] core_predicted;

    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_class;
    logic [1:0] res_err;

    modport master (
        input  s_valid, s_data, s_last, core_done, core_predicted, res_ready,
        output s_ready, core_pix_we, core_pix_addr, core_pix_data, core_start,
               res_valid, res_class, res_err
    );

    modport slave (
        output s_valid, s_data, s_last, core_done, core_predicted, res_ready,
        input  s_ready, core_pix_we, core_pix_addr, core_pix_data, core_start,
               res_valid, res_class, res_err
    );
endinterface

// File: rtl/nn_frame_seq.sv
// Frame sequencer: streams one pixel frame into nn_core, runs the core's start/done
// handshake and returns the predicted class plus an error code on a result handshake.
module nn_frame_seq #(
    parameter int N_IN    = 784,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    nn_frame_seq_if.master        bus,
    output logic                  busy,
    output logic [15:0]           frame_count
);
    localparam int AW = 10;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N_IN - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_LONG    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE, LOAD, DRAIN, START, WAIT, RESULT, REARM
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [TW-1:0] timer;
    logic          beat;

    assign beat = bus.s_valid & bus.s_ready;
    assign busy = (state != IDLE);

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking writes would let later statements see same-cycle values and break the edge timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            idx               <= '0;
            timer             <= '0;
            bus.s_ready       <= 1'b0;
            bus.core_pix_we   <= 1'b0;
            bus.core_pix_addr <= '0;
            bus.core_pix_data <= '0;
            bus.core_start    <= 1'b0;
            bus.res_valid     <= 1'b0;
            bus.res_class     <= '0;
            bus.res_err       <= ERR_OK;
            frame_count       <= '0;
        end else begin
            // NOTE: default low makes the pixel write a single-cycle pulse per accepted beat.
            bus.core_pix_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        idx         <= '0;
                        bus.s_ready <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        bus.core_pix_we   <= 1'b1;
                        bus.core_pix_addr <= idx;
                        bus.core_pix_data <= bus.s_data;
                        idx               <= idx + 1'b1;
                        if (bus.s_last) begin
                            bus.s_ready <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state <= START;
                            end else begin
                                bus.res_err   <= ERR_SHORT;
                                bus.res_class <= '0;
                                bus.res_valid <= 1'b1;
                                state         <= RESULT;
                            end
                        end else if (idx == LAST_IDX) begin
                            // Frame is full but the source keeps going: swallow the tail.
                            bus.res_err   <= ERR_LONG;
                            bus.res_class <= '0;
                            state         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && bus.s_last) begin
                        bus.s_ready   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= RESULT;
                    end
                end
                START: begin
                    bus.core_start <= 1'b1;
                    timer          <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (bus.core_done) begin
                        bus.res_class <= bus.core_predicted;
                        bus.res_err   <= ERR_OK;
                        bus.res_valid <= 1'b1;
                        state         <= RESULT;
                    end else if (timer == TIMER_MAX) begin
                        bus.res_class <= '0;
                        bus.res_err   <= ERR_TIMEOUT;
                        bus.res_valid <= 1'b1;
                        state         <= RESULT;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid  <= 1'b0;
                        bus.core_start <= 1'b0;
                        if (bus.res_err == ERR_OK) frame_count <= frame_count + 1'b1;
                        state <= REARM;
                    end
                end
                REARM: begin
                    // The core holds done until it sees start drop; wait it out before rearming.
                    if (!bus.core_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_frame_seq.sv
// Self-checking bench for nn_frame_seq: table-driven frames, randomized frames against a
// frame-level reference model, and a mid-load reset sequence. A small stub stands in for nn_core.
module tb_nn_frame_seq;
    localparam int N_IN = 784;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] frame_count;

    nn_frame_seq_if bus();

    nn_frame_seq #(.N_IN(N_IN), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Core stub: done rises stub_lat cycles after start is seen high (never when 0),
    // and drops the cycle after start falls.
    int         stub_lat  = 0;
    logic [3:0] stub_pred = '0;
    int         stub_cnt  = 0;
    logic       done_r    = 1'b0;

    always @(posedge clk) begin
        if (rst || !bus.core_start) begin
            stub_cnt <= 0;
            done_r   <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == stub_lat) done_r <= 1'b1;
        end
    end
    assign bus.core_done      = done_r;
    assign bus.core_predicted = stub_pred;

    // Monitor: logs core writes and edge times of core_start / res_valid; clears on each new frame.
    int         cyc = 0;
    int         wr_cnt = 0, addr_bad = 0, last_wr_cyc = 0, start_cyc = 0, rv_cyc = 0;
    bit         start_seen = 0;
    logic [7:0] wr_mem [0:1023];
    logic       prev_start = 1'b0, prev_rv = 1'b0, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            wr_cnt     = 0;
            addr_bad   = 0;
            start_seen = 0;
        end
        if (bus.core_pix_we === 1'b1) begin
            if (int'(bus.core_pix_addr) != wr_cnt) addr_bad++;
            wr_mem[bus.core_pix_addr] = bus.core_pix_data;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (bus.core_start && !prev_start) begin
            start_seen = 1;
            start_cyc  = cyc;
        end
        if (bus.res_valid && !prev_rv) rv_cyc = cyc;
        prev_start = bus.core_start;
        prev_rv    = bus.res_valid;
        prev_busy  = busy;
    end

    typedef struct {
        int         n;
        int         lat;
        int         gap;
        int         dly;
        logic [3:0] pred;
        int         p0;
        logic [1:0] exp_err;
        logic [3:0] exp_class;
        int         exp_wr;
        int         exp_lat;   // cycles core_start rise -> res_valid rise; 0 = start never raised
    } vec_t;

    logic [7:0] pix [0:1023];
    int         exp_fc = 0;

    // Reference model at frame level: the outcome follows from beat count and core latency alone.
    function automatic vec_t model(input int n, input int lat, input int gap, input int dly,
                                   input logic [3:0] pred);
        vec_t v;
        v.n = n; v.lat = lat; v.gap = gap; v.dly = dly; v.pred = pred; v.p0 = -1;
        v.exp_wr = (n < N_IN) ? n : N_IN;
        if (n < N_IN)                    v.exp_err = 2'd1;
        else if (n > N_IN)               v.exp_err = 2'd2;
        else if (lat >= 1 && lat <= TO)  v.exp_err = 2'd0;
        else                             v.exp_err = 2'd3;
        v.exp_class = (v.exp_err == 2'd0) ? pred : 4'd0;
        if (n != N_IN)                   v.exp_lat = 0;
        else if (v.exp_err == 2'd0)      v.exp_lat = lat + 1;
        else                             v.exp_lat = TO + 1;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int         i, budget, w, stab, dbad;
        logic [3:0] cap_class;
        logic [1:0] cap_err;
        logic       cap_start;
        stub_lat  = v.lat;
        stub_pred = v.pred;
        for (int k = 0; k < v.n; k++) pix[k] = 8'($urandom);
        if (v.p0 >= 0) pix[0] = 8'(v.p0);

        @(negedge clk);
        enable = 1'b1;
        i = 0;
        budget = 0;
        while (i < v.n && budget < 8 * v.n + 50) begin
            @(negedge clk);
            budget++;
            enable = 1'b0;
            bus.s_valid = ($urandom_range(99) >= v.gap);
            bus.s_data  = pix[i];
            bus.s_last  = (i == v.n - 1);
            if (bus.s_valid && bus.s_ready) i++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check({tag, " beats_accepted"}, i, v.n);

        w = 0;
        while (!bus.res_valid && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " res_valid"}, bus.res_valid, 1);
        cap_class = bus.res_class;
        cap_err   = bus.res_err;
        cap_start = bus.core_start;
        stab = 0;
        for (int d = 0; d < v.dly; d++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_class != cap_class || bus.res_err != cap_err ||
                bus.core_start != cap_start) stab++;
        end
        check({tag, " res_err"}, bus.res_err, v.exp_err);
        check({tag, " res_class"}, bus.res_class, v.exp_class);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        if (v.exp_err == 2'd0) exp_fc = (exp_fc + 1) & 16'hFFFF;

        check({tag, " hold_stable"}, stab, 0);
        check({tag, " res_valid_drop"}, bus.res_valid, 0);
        check({tag, " start_drop"}, bus.core_start, 0);
        check({tag, " frame_count"}, frame_count, exp_fc);
        check({tag, " writes"}, wr_cnt, v.exp_wr);
        check({tag, " addr_order"}, addr_bad, 0);
        dbad = 0;
        for (int k = 0; k < v.exp_wr; k++) if (wr_mem[k] !== pix[k]) dbad++;
        check({tag, " pix_data"}, dbad, 0);
        check({tag, " start_seen"}, start_seen, (v.exp_lat != 0));
        if (v.exp_lat != 0) begin
            check({tag, " result_latency"}, rv_cyc - start_cyc, v.exp_lat);
            check({tag, " start_after_write"}, start_cyc - last_wr_cyc, 1);
        end

        w = 0;
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " idle_after"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " s_ready"}, bus.s_ready, 0);
        check({tag, " pix_we"}, bus.core_pix_we, 0);
        check({tag, " pix_addr"}, bus.core_pix_addr, 0);
        check({tag, " core_start"}, bus.core_start, 0);
        check({tag, " res_valid"}, bus.res_valid, 0);
        check({tag, " res_class"}, bus.res_class, 0);
        check({tag, " res_err"}, bus.res_err, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " frame_count"}, frame_count, 0);
    endtask

    vec_t tbl [11];

    initial begin
        int   i, budget;
        vec_t v;
        string tag;

        //             n    lat gap dly pred  p0     err   cls   wr   lat
        tbl[0]  = '{784,   5,  0,  0, 4'd7, 'h37, 2'd0, 4'd7, 784,   6};
        tbl[1]  = '{100,   5,  0,  0, 4'd9,   -1, 2'd1, 4'd0, 100,   0};
        tbl[2]  = '{790,   5,  0,  0, 4'd3,   -1, 2'd2, 4'd0, 784,   0};
        tbl[3]  = '{784,   0,  0,  0, 4'd4,   -1, 2'd3, 4'd0, 784,  21};
        tbl[4]  = '{784,   3,  0,  0, 4'd2,   -1, 2'd0, 4'd2, 784,   4};
        tbl[5]  = '{784,   8, 30, 10, 4'd11,  -1, 2'd0, 4'd11, 784,  9};
        tbl[6]  = '{784,  20,  0,  0, 4'd5,   -1, 2'd0, 4'd5, 784,  21};
        tbl[7]  = '{784,  21,  0,  0, 4'd6,   -1, 2'd3, 4'd0, 784,  21};
        tbl[8]  = '{783,   5,  0,  0, 4'd1,   -1, 2'd1, 4'd0, 783,   0};
        tbl[9]  = '{785,   5,  0,  0, 4'd1,   -1, 2'd2, 4'd0, 784,   0};
        tbl[10] = '{1,     5,  0,  0, 4'd1,   -1, 2'd1, 4'd0,   1,   0};

        rst           = 1'b1;
        enable        = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int t = 0; t < 11; t++) begin
            tag = $sformatf("vec%0d", t);
            run_frame(tbl[t], tag);
        end

        for (int r = 0; r < 6; r++) begin
            int n;
            case ($urandom_range(3))
                0, 1:    n = N_IN;
                2:       n = int'($urandom_range(783, 1));
                default: n = int'($urandom_range(800, 785));
            endcase
            v = model(n, int'($urandom_range(24)), int'($urandom_range(25)),
                      int'($urandom_range(5)), 4'($urandom));
            tag = $sformatf("rnd%0d", r);
            run_frame(v, tag);
        end

        // Reset while loading pixel 400: everything clears, the count restarts from zero.
        for (int k = 0; k < N_IN; k++) pix[k] = 8'($urandom);
        @(negedge clk);
        enable = 1'b1;
        i = 0;
        budget = 0;
        while (i < 400 && budget < 1000) begin
            @(negedge clk);
            budget++;
            enable      = 1'b0;
            bus.s_valid = 1'b1;
            bus.s_data  = pix[i];
            bus.s_last  = 1'b0;
            if (bus.s_ready) i++;
        end
        check("midreset beats", i, 400);
        check("midreset busy_before", busy, 1);
        @(negedge clk);
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst    = 1'b0;
        exp_fc = 0;
        run_frame(tbl[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
